// File: rtl/cpu_run_controller.sv
// cpu_run_controller: owns the run lifecycle of the 8-bit CPU.
// It streams a 2**ADDR_W byte image into CPU memory over a valid/ready
// interface, holds the CPU in reset while loading, then releases it and
// watches cpu_halt. It counts executed cycles, enforces a watchdog limit,
// and pulses done on completion.
module cpu_run_controller #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int MAX_CYCLES = 255,
  parameter int CNT_W      = 8
) (
  input  logic              clk_signal,
  input  logic              reset_n,      // active-high despite the name
  input  logic              abort,
  input  logic              start,
  input  logic              run_only,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  input  logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_CYCLES);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_next;
  logic [CNT_W-1:0]  count_next;
  logic [CNT_W-1:0]  count_inc;
  logic              timeout_next;
  logic              done_next;
  logic              handshake;

  // A byte moves only while loading and the host offers one.
  assign handshake = (state == LOAD) && load_valid;
  assign count_inc = cycle_count + CNT_ONE;

  // The memory write happens in the handshake cycle itself, even if abort
  // is also asserted; the CPU stays in reset until RUN.
  assign load_ready = (state == LOAD);
  assign mem_we     = handshake;
  assign mem_addr   = ptr;
  assign mem_wdata  = load_data;
  assign cpu_reset  = (state == IDLE) || (state == LOAD);
  assign busy       = (state == LOAD) || (state == RUN);

  // Next-state, pointer, counter and status decode; abort overrides all.
  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    count_next   = cycle_count;
    timeout_next = timeout;
    done_next    = 1'b0;
    if (abort) begin
      state_next = IDLE;
      ptr_next   = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            count_next   = '0;
            timeout_next = 1'b0;
            if (run_only) begin
              state_next = RUN;
            end else begin
              state_next = LOAD;
              ptr_next   = '0;
            end
          end else begin
            state_next = state;
          end
        end
        LOAD: begin
          if (handshake) begin
            ptr_next = ptr + PTR_ONE;
            if (ptr == PTR_LAST) begin
              state_next = RUN;
            end else begin
              state_next = LOAD;
            end
          end else begin
            state_next = LOAD;
          end
        end
        RUN: begin
          // Halt is checked first so it wins over a simultaneous expiry.
          if (cpu_halt) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            count_next = count_inc;
            if (count_inc == CNT_MAX) begin
              state_next   = DONE;
              timeout_next = 1'b1;
              done_next    = 1'b1;
            end else begin
              state_next = RUN;
            end
          end
        end
        default: begin
          state_next = IDLE;
          ptr_next   = '0;
        end
      endcase
    end
  end

  // State and datapath registers; reset asserts asynchronously.
  always_ff @(posedge clk_signal or posedge reset_n) begin
    if (reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      cycle_count <= count_next;
      timeout     <= timeout_next;
      done        <= done_next;
    end
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Sequencer that owns the 8-bit CPU's run lifecycle.
- Streams a 32-byte program image into the CPU's 32x8 memory over a valid/ready byte interface.
- Holds the CPU in reset during load, then releases it.
- Monitors the CPU halt signal, counts executed cycles, enforces a watchdog limit, and reports completion.
- Sits between the test/host side and the CPU and its memory write port.

Parameters:
ADDR_W, 5, memory address width; image length is 2**ADDR_W bytes
DATA_W, 8, memory word width
MAX_CYCLES, 255, watchdog limit on RUN cycles; must satisfy 1 <= MAX_CYCLES <= 255
CNT_W, 8, width of cycle_count

Ports:
clk_signal  in  1  single clock; all state changes on its rising edge
reset_n  in  1  asynchronous, active-high reset; the name is kept from the existing codebase although the polarity is high
abort  in  1  return to IDLE from any state
start  in  1  begin a sequence; sampled only in IDLE or DONE
run_only  in  1  qualifies start: 1 = skip LOAD and go straight to RUN
load_valid  in  1  image byte valid
load_data  in  DATA_W  image byte
load_ready  out  1  controller accepts a byte
mem_we  out  1  CPU memory write strobe
mem_addr  out  ADDR_W  CPU memory write address
mem_wdata  out  DATA_W  CPU memory write data
cpu_reset  out  1  drives CPU reset (active-high)
cpu_halt  in  1  CPU halt indication (opcode 000 at the current PC)
busy  out  1  high in LOAD or RUN
done  out  1  one-cycle pulse on entry to DONE
timeout  out  1  sticky; set when the watchdog expires
cycle_count  out  CNT_W  RUN cycles without halt

Behaviour:
- Reset (async assert, released synchronously by the system):
  - state=IDLE, ptr=0, cpu_reset=1, load_ready=0, mem_we=0, busy=0, done=0, timeout=0, cycle_count=0.
  - An assertion mid-LOAD or mid-RUN aborts immediately; a partial image stays in memory.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - cpu_reset=1.
  - start & !run_only -> LOAD, ptr=0.
  - start & run_only -> RUN.
  - Both transitions clear cycle_count and timeout.
- LOAD:
  - cpu_reset=1, load_ready=1.
  - Handshake = load_valid & load_ready. On a handshake:
    - mem_we=1, mem_addr=ptr, mem_wdata=load_data (combinational, same cycle).
    - ptr increments at the clock edge.
  - No handshake -> mem_we=0; ptr holds. Gaps in load_valid are legal.
  - Handshake with ptr=31 -> RUN next cycle; ptr wraps to 0.
  - load_ready=0 in every other state; load_valid outside LOAD is ignored.
- RUN:
  - cpu_reset=0 and busy=1 in every RUN cycle.
  - cpu_halt is sampled every RUN cycle, including the first.
  - cpu_halt=1 -> DONE; cycle_count holds.
  - cpu_halt=0 -> cycle_count+1. If the new value equals MAX_CYCLES -> DONE with timeout=1.
  - cycle_count therefore equals the number of instructions executed before halt.
  - Halt and watchdog expiry in the same cycle: halt wins, timeout stays 0.
- DONE:
  - done=1 in the first DONE cycle only.
  - cpu_reset=0, so the halted CPU state remains inspectable; busy=0.
  - cycle_count and timeout hold.
  - start -> LOAD or RUN per run_only, same as IDLE.
- start while in LOAD or RUN: ignored.
- abort:
  - Any state -> IDLE next edge; cpu_reset=1 from that edge; no done pulse.
  - timeout and cycle_count hold their values.
  - abort has priority over start, a handshake, and cpu_halt in the same cycle.
  - An abort in a handshake cycle still performs that combinational write; ptr is reset to 0.
- Widths: cycle_count saturates by construction (MAX_CYCLES <= 2**CNT_W-1); ptr wraps modulo 2**ADDR_W.

Test Plan:
1. Full load and run:
   - Image: bytes 0..2 = 0x21 (ADD [1]), byte 3 = 0x00, rest 0x00.
   - Required: 32 writes at addresses 0..31 in order; cpu_reset low on the first RUN cycle; done pulses once; cycle_count=3, timeout=0, busy low in DONE.
2. Backpressure:
   - load_valid toggles every other cycle.
   - Required: mem_we only on handshake cycles, addresses contiguous, LOAD lasts 63 cycles, no duplicate or skipped address.
3. Watchdog:
   - Image all 0x20 (never halts), MAX_CYCLES=255.
   - Required: DONE after 255 RUN cycles, cycle_count=255, timeout=1, done pulse.
4. Immediate halt with run_only:
   - From DONE of test 1, rewrite is skipped; start=1, run_only=1, with byte 0 = 0x00 preloaded.
   - Required: RUN for 1 cycle, cycle_count=0, no mem_we.
5. Abort:
   - Assert abort on the 10th RUN cycle, with start=1 in the same cycle.
   - Required: IDLE next edge, cpu_reset=1, no done pulse, start ignored, cycle_count holds 9.
6. Async reset mid-LOAD:
   - Assert reset_n after 12 bytes, between clock edges.
   - Required: cpu_reset=1, load_ready=0, mem_we=0 immediately, before the next edge; after release, a new start reloads from address 0.
